// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the shared snooping bus.
// Picks one eligible cache controller per transaction, broadcasts its
// {source, addr, tx} for one cycle, then holds the bus until done or timeout.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req[NUM_CPUS]     per-CPU bus request, held until granted
//   req_addr, req_tx  per-CPU packed address and tx code (0 Idle,1 GetS,2 GetM,3 PutM)
//   done              current transaction complete
//   gnt, bus_valid    one-hot grant and broadcast strobe, 1-cycle pulses
//   bus_source/addr/tx latched winner, held until the next grant
//   busy              bus owned (broadcast or waiting)
//   timeout_err       1-cycle pulse when a transaction is aborted
module snoop_bus_arbiter #(
    parameter int NUM_CPUS = 4,
    parameter int XLEN     = 6,
    parameter int SRC_W    = $clog2(NUM_CPUS),
    parameter int TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CPUS-1:0]      req,
    input  logic [NUM_CPUS*XLEN-1:0] req_addr,
    input  logic [NUM_CPUS*2-1:0]    req_tx,
    input  logic                     done,
    output logic [NUM_CPUS-1:0]      gnt,
    output logic                     bus_valid,
    output logic [SRC_W-1:0]         bus_source,
    output logic [XLEN-1:0]          bus_addr,
    output logic [1:0]               bus_tx,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BCAST = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]          state;
    logic [SRC_W-1:0]    rr_ptr;
    logic [CW-1:0]       wait_cnt;
    logic [NUM_CPUS-1:0] elig;
    logic [SRC_W-1:0]    win;
    logic                found;

    // A request carrying the Idle tx code is not a bus transaction.
    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++)
            elig[i] = req[i] && (req_tx[i*2 +: 2] != 2'd0);
    end

    // First eligible requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % NUM_CPUS]) begin
                found = 1'b1;
                win   = SRC_W'((int'(rr_ptr) + k) % NUM_CPUS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            gnt         <= '0;
            bus_valid   <= 1'b0;
            bus_source  <= '0;
            bus_addr    <= '0;
            bus_tx      <= 2'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            gnt         <= '0;
            bus_valid   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    state      <= BCAST;
                    gnt        <= NUM_CPUS'(1) << win;
                    bus_valid  <= 1'b1;
                    busy       <= 1'b1;
                    bus_source <= win;
                    bus_addr   <= req_addr[win*XLEN +: XLEN];
                    bus_tx     <= req_tx[win*2 +: 2];
                end
                BCAST: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                    rr_ptr   <= (int'(bus_source) == NUM_CPUS-1) ? '0 : bus_source + 1'b1;
                end
                WAIT: begin
                    // done takes precedence over an expiring counter.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == CW'(TIMEOUT-1)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed scoreboard bench for snoop_bus_arbiter.
// Stimulus pushes expected grant/timeout events with their cycle numbers;
// a negedge monitor pops and compares whenever bus_valid or timeout_err fires.
module tb_snoop_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [23:0] req_addr;
    logic [7:0] req_tx;
    logic       done;
    logic [3:0] gnt;
    logic       bus_valid;
    logic [1:0] bus_source;
    logic [5:0] bus_addr;
    logic [1:0] bus_tx;
    logic       busy;
    logic       timeout_err;

    logic [5:0] a   [4];
    logic [1:0] txv [4];

    typedef struct {
        int         cyc;
        logic       err;
        logic [1:0] src;
        logic [5:0] addr;
        logic [1:0] tx;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    snoop_bus_arbiter #(.NUM_CPUS(4), .XLEN(6), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_tx(req_tx),
        .done(done), .gnt(gnt), .bus_valid(bus_valid), .bus_source(bus_source),
        .bus_addr(bus_addr), .bus_tx(bus_tx), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_addr = '0;
        req_tx   = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*6 +: 6] = a[i];
            req_tx[i*2 +: 2]   = txv[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int s, input int dt);
        q.push_back('{cyc + dt, 1'b0, 2'(s), a[s], txv[s]});
    endtask

    task automatic expect_err(input int dt);
        q.push_back('{cyc + dt, 1'b1, 2'd0, 6'd0, 2'd0});
    endtask

    // From a grant cycle: release req, complete with done in the first WAIT cycle.
    task automatic finish_txn();
        req = 4'b0000;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus_valid) check("gnt_without_valid", 32'(gnt), 32'd0);
            if (bus_valid || timeout_err) begin
                check("event_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    check("event_cycle", cyc, mon_e.cyc);
                    check("event_is_err", 32'(timeout_err), 32'(mon_e.err));
                    if (!mon_e.err) begin
                        check("gnt", 32'(gnt), 32'(4'b0001 << mon_e.src));
                        check("bus_source", 32'(bus_source), 32'(mon_e.src));
                        check("bus_addr", 32'(bus_addr), 32'(mon_e.addr));
                        check("bus_tx", 32'(bus_tx), 32'(mon_e.tx));
                        check("busy_bcast", 32'(busy), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        a[0] = 6'h05; a[1] = 6'h1B; a[2] = 6'h2A; a[3] = 6'h3F;
        txv[0] = 2'd1; txv[1] = 2'd2; txv[2] = 2'd2; txv[3] = 2'd3;
        step(3);
        check("reset_outputs", 32'({gnt, bus_valid, bus_source, bus_addr, bus_tx, busy, timeout_err}), 32'd0);
        rst = 1'b0;
        step(1);
        // single GetM from CPU2
        req = 4'b0100; expect_grant(2, 1);
        step(1);
        req = 4'b0000;
        step(1);
        check("t1_wait_busy", 32'({busy, bus_valid}), 32'b10);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("t1_idle_hold", 32'({busy, bus_addr}), 32'({1'b0, 6'h2A}));
        // fairness from a fresh pointer, done two cycles after each grant
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) expect_grant(k % 4, 1 + 4*k);
        step(1);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req = 4'b0000;
            step(2);
            done = 1'b1;
            step(1);
            done = 1'b0;
            step(1);
        end
        // wrap: grant CPU2 so rr_ptr=3, then 0011 -> CPU0 then CPU1
        req = 4'b0100; expect_grant(2, 1);
        step(1);
        finish_txn();
        req = 4'b0011; expect_grant(0, 1); expect_grant(1, 4);
        step(1);
        req = 4'b0010;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(1);
        finish_txn();
        // Idle-tx request is never granted
        txv[0] = 2'd0; req = 4'b0001;
        step(6);
        check("t4_no_grant", 32'(busy), 32'd0);
        txv[1] = 2'd1; req = 4'b0011; expect_grant(1, 1);
        step(1);
        finish_txn();
        txv[0] = 2'd1;
        // timeout after 8 WAIT cycles
        req = 4'b1000; expect_grant(3, 1); expect_err(10);
        step(1);
        req = 4'b0000;
        step(9);
        check("t5_err_idle", 32'({timeout_err, busy}), 32'b10);
        step(1);
        check("t5_err_pulse", 32'(timeout_err), 32'd0);
        // done on the limit cycle wins
        req = 4'b1000; expect_grant(3, 1);
        step(1);
        req = 4'b0000;
        step(8);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("t5_done_wins", 32'({timeout_err, busy}), 32'd0);
        step(1);
        // reset in WAIT
        req = 4'b0100; expect_grant(2, 1);
        step(1);
        req = 4'b0000;
        step(1);
        rst = 1'b1;
        step(1);
        check("t6_reset_outputs", 32'({gnt, bus_valid, bus_source, bus_addr, bus_tx, busy, timeout_err}), 32'd0);
        rst = 1'b0; req = 4'b1001; expect_grant(0, 1);
        step(1);
        req = 4'b1000;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        expect_grant(3, 1);
        step(1);
        finish_txn();
        step(3);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
